mcif_rd_eng: RTL and testbench

- AXI4 read engine directly downstream of the feature-data DMA command generator.
- Accepts read commands {burst_len-1, base_addr, offset} and issues AXI AR bursts at base+offset.
- Returns R-channel beats to the CNN input buffer through a credit-protected data FIFO, so accepted data can never overflow the FIFO.

---
 rtl/mcif_rd_eng_pkg.sv | 22 ++
 rtl/mcif_sync_fifo.sv | 50 +++++
 rtl/mcif_rd_eng.sv | 145 ++++++++++++++
 tb/tb_mcif_rd_eng.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcif_rd_eng_pkg.sv
// rtl/mcif_rd_eng_pkg.sv - shared AXI constants and command field layout for the read engine
package mcif_rd_eng_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // rd_req_pd = {len_m1, base_addr, offset}; offset sits in the LSBs
   localparam int OFFS_LSB = 0;

   function automatic int base_lsb(input int addr_w);
      return addr_w;
   endfunction

   function automatic int len_lsb(input int addr_w);
      return 2 * addr_w;
   endfunction

   function automatic logic [2:0] axi_size(input int dw);
      return 3'($clog2(dw / 8));
   endfunction

endpackage

// File: rtl/mcif_sync_fifo.sv
// rtl/mcif_sync_fifo.sv - single-clock FIFO with full/empty/count, head entry presented at rdata
module mcif_sync_fifo
   import mcif_rd_eng_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/mcif_rd_eng.sv
// rtl/mcif_rd_eng.sv - AXI4 read engine: command to AR bursts, R beats into a credit-protected data FIFO
module mcif_rd_eng
   import mcif_rd_eng_pkg::*;
#(
   parameter int LOG2_BURST_LEN = 4,
   parameter int ADDR_W         = 32,
   parameter int DW             = 128,
   parameter int MAX_OUTST      = 4,
   parameter int FIFO_DEPTH     = 64
)(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             rd_req_vld,
   output logic                             rd_req_rdy,
   input  logic [LOG2_BURST_LEN+2*ADDR_W-1:0] rd_req_pd,
   output logic                             arvalid,
   input  logic                             arready,
   output logic [ADDR_W-1:0]                araddr,
   output logic [7:0]                       arlen,
   output logic [2:0]                       arsize,
   output logic [1:0]                       arburst,
   input  logic                             rvalid,
   output logic                             rready,
   input  logic [DW-1:0]                    rdata,
   input  logic [1:0]                       rresp,
   input  logic                             rlast,
   output logic                             dat_vld,
   input  logic                             dat_rdy,
   output logic [DW-1:0]                    dat_pd,
   input  logic                             err_clr,
   output logic                             err_rresp,
   output logic                             err_rlast,
   output logic                             busy
);

   localparam int LW       = LOG2_BURST_LEN;
   localparam int RW       = $clog2(FIFO_DEPTH) + 1;
   localparam int RW1      = RW + 1;
   localparam int OW       = $clog2(MAX_OUTST) + 1;
   localparam int LEN_LSB  = len_lsb(ADDR_W);
   localparam int BASE_LSB = base_lsb(ADDR_W);

   logic [LW-1:0]     len_m1;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] offset;
   logic [RW-1:0]     reserved;
   logic [RW1-1:0]    need;
   logic [OW-1:0]     outst;
   logic [OW-1:0]     outst_next;
   logic [7:0]        beat_idx;
   logic [7:0]        len_head;
   logic              len_empty;
   logic              len_bad;
   logic              dat_full;
   logic              dat_empty;
   logic              ar_hs, r_hs, r_last, out_dec, pop, fit, accept;
   logic [$clog2(FIFO_DEPTH):0] unused_dat_cnt;
   logic [$clog2(MAX_OUTST):0]  unused_len_cnt;
   logic                        unused_len_full;

   assign len_m1    = rd_req_pd[LEN_LSB +: LW];
   assign base_addr = rd_req_pd[BASE_LSB +: ADDR_W];
   assign offset    = rd_req_pd[OFFS_LSB +: ADDR_W];

   assign ar_hs   = arvalid & arready;
   assign r_hs    = rvalid & rready;
   assign r_last  = r_hs & rlast;
   assign out_dec = r_last & (outst != '0);
   assign pop     = dat_vld & dat_rdy;

   // Credit check uses the current count; a same-cycle pop only helps next cycle
   assign need       = RW1'(reserved) + RW1'(len_m1) + RW1'(1);
   assign fit        = (need <= RW1'(FIFO_DEPTH));
   assign outst_next = outst + OW'(ar_hs) - OW'(out_dec);
   assign rd_req_rdy = (~arvalid | arready) & fit & (outst_next < OW'(MAX_OUTST));
   assign accept     = rd_req_vld & rd_req_rdy;

   assign arsize  = axi_size(DW);
   assign arburst = AXI_BURST_INCR;
   assign rready  = ~dat_full;
   assign dat_vld = ~dat_empty;
   assign busy    = arvalid | (outst != '0) | (reserved != '0);

   // A beat with no burst expected also counts as a framing error
   assign len_bad = len_empty | (rlast ? (beat_idx != len_head) : (beat_idx == len_head));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arvalid  <= 1'b0;
         araddr   <= '0;
         arlen    <= '0;
         reserved <= '0;
         outst    <= '0;
      end else begin
         if (accept) begin
            arvalid <= 1'b1;
            araddr  <= base_addr + offset;
            arlen   <= 8'(len_m1);
         end else if (arready) begin
            arvalid <= 1'b0;
         end
         reserved <= reserved + (accept ? RW'(len_m1) + RW'(1) : '0) - RW'(pop);
         outst    <= outst_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_idx  <= '0;
         err_rresp <= 1'b0;
         err_rlast <= 1'b0;
      end else begin
         if (r_hs) beat_idx <= rlast ? 8'd0 : beat_idx + 8'd1;
         if (r_hs && (rresp != AXI_RESP_OKAY)) err_rresp <= 1'b1;
         else if (err_clr)                      err_rresp <= 1'b0;
         if (r_hs && len_bad) err_rlast <= 1'b1;
         else if (err_clr)    err_rlast <= 1'b0;
      end
   end

   mcif_sync_fifo #(.WIDTH(8), .DEPTH(MAX_OUTST)) u_len_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ar_hs),
      .wdata (arlen),
      .pop   (r_last),
      .rdata (len_head),
      .full  (unused_len_full),
      .empty (len_empty),
      .count (unused_len_cnt)
   );

   mcif_sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_dat_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (r_hs),
      .wdata (rdata),
      .pop   (pop),
      .rdata (dat_pd),
      .full  (dat_full),
      .empty (dat_empty),
      .count (unused_dat_cnt)
   );

endmodule

// File: tb/tb_mcif_rd_eng.sv
// tb/tb_mcif_rd_eng.sv - directed self-checking bench for mcif_rd_eng
module tb_mcif_rd_eng;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         rd_req_vld = 1'b0;
   logic         rd_req_rdy;
   logic [67:0]  rd_req_pd = '0;
   logic         arvalid;
   logic         arready = 1'b0;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         rvalid = 1'b0;
   logic         rready;
   logic [127:0] rdata = '0;
   logic [1:0]   rresp = 2'b00;
   logic         rlast = 1'b0;
   logic         dat_vld;
   logic         dat_rdy = 1'b0;
   logic [127:0] dat_pd;
   logic         err_clr = 1'b0;
   logic         err_rresp;
   logic         err_rlast;
   logic         busy;

   int total = 0;
   int bad   = 0;

   mcif_rd_eng dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_req_vld (rd_req_vld),
      .rd_req_rdy (rd_req_rdy),
      .rd_req_pd  (rd_req_pd),
      .arvalid    (arvalid),
      .arready    (arready),
      .araddr     (araddr),
      .arlen      (arlen),
      .arsize     (arsize),
      .arburst    (arburst),
      .rvalid     (rvalid),
      .rready     (rready),
      .rdata      (rdata),
      .rresp      (rresp),
      .rlast      (rlast),
      .dat_vld    (dat_vld),
      .dat_rdy    (dat_rdy),
      .dat_pd     (dat_pd),
      .err_clr    (err_clr),
      .err_rresp  (err_rresp),
      .err_rlast  (err_rlast),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [3:0] len, input logic [31:0] base, input logic [31:0] offs,
                           output bit ok);
      ok = 1'b0;
      rd_req_vld = 1'b1;
      rd_req_pd  = {len, base, offs};
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         ok = rd_req_rdy;
         tick();
      end
      rd_req_vld = 1'b0;
   endtask

   task automatic ret_burst(input int n, input logic [15:0] lm, input logic [15:0] rm,
                            input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         rvalid = 1'b1;
         rdata  = {96'h0, base + 32'(i)};
         rlast  = lm[i];
         rresp  = rm[i] ? 2'b10 : 2'b00;
         tick();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
   endtask

   task automatic drain(input int n, input logic [31:0] base, output int errs);
      errs = 0;
      for (int i = 0; i < n; i++) begin
         for (int w = 0; w < 20 && !dat_vld; w++) tick();
         if (!dat_vld) errs++;
         else if (dat_pd !== {96'h0, base + 32'(i)}) errs++;
         dat_rdy = 1'b1;
         tick();
         dat_rdy = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
      total++; if (araddr !== 32'h0) begin bad++; $display("FAIL reset_araddr got=%h exp=0", araddr); end
      total++; if (arlen !== 8'h0) begin bad++; $display("FAIL reset_arlen got=%h exp=0", arlen); end
      total++; if (dat_vld !== 1'b0) begin bad++; $display("FAIL reset_dat_vld got=%b exp=0", dat_vld); end
      total++; if ({err_rresp, err_rlast} !== 2'b00) begin bad++; $display("FAIL reset_errs got=%b exp=00", {err_rresp, err_rlast}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst_n = 1'b1;
      tick();
      total++; if (rready !== 1'b1) begin bad++; $display("FAIL reset_rready got=%b exp=1", rready); end
      total++; if (arsize !== 3'd4) begin bad++; $display("FAIL arsize got=%0d exp=4", arsize); end
      total++; if (arburst !== 2'b01) begin bad++; $display("FAIL arburst got=%b exp=01", arburst); end
   endtask

   task automatic test_single();
      bit ok;
      int e = 0;
      arready = 1'b0;
      dat_rdy = 1'b0;
      send_cmd(4'd3, 32'h1000_0000, 32'h40, ok);
      total++; if (!ok) begin bad++; $display("FAIL single_accept got=timeout exp=accept"); end
      total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL single_arvalid got=%b exp=1", arvalid); end
      total++; if (araddr !== 32'h1000_0040) begin bad++; $display("FAIL single_araddr got=%h exp=10000040", araddr); end
      total++; if (arlen !== 8'd3) begin bad++; $display("FAIL single_arlen got=%0d exp=3", arlen); end
      arready = 1'b1;
      tick();
      arready = 1'b0;
      total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL single_arvalid_drop got=%b exp=0", arvalid); end
      for (int i = 0; i < 4; i++) begin
         if (dat_vld !== 1'b0) e++;
         rvalid = 1'b1;
         rdata  = {96'h0, 32'hA0 + 32'(i)};
         rlast  = (i == 3);
         tick();
         rvalid = 1'b0;
         rlast  = 1'b0;
         if (dat_vld !== 1'b1 || dat_pd !== {96'h0, 32'hA0 + 32'(i)}) e++;
         dat_rdy = 1'b1;
         tick();
         dat_rdy = 1'b0;
      end
      total++; if (e != 0) begin bad++; $display("FAIL single_beats got=%0d_errors exp=0", e); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
   endtask

   task automatic test_credit();
      int n = 0;
      int e;
      arready    = 1'b1;
      dat_rdy    = 1'b0;
      rd_req_vld = 1'b1;
      rd_req_pd  = {4'hF, 32'h0, 32'h0};
      for (int i = 0; i < 8; i++) begin
         #1;
         if (rd_req_rdy) n++;
         tick();
      end
      rd_req_vld = 1'b0;
      total++; if (n != 4) begin bad++; $display("FAIL credit_accepts got=%0d exp=4", n); end
      #1;
      total++; if (rd_req_rdy !== 1'b0) begin bad++; $display("FAIL credit_rdy_full got=%b exp=0", rd_req_rdy); end
      ret_burst(16, 16'h8000, 16'h0, 32'h100);
      total++; if (rd_req_rdy !== 1'b0) begin bad++; $display("FAIL credit_rdy_after_data got=%b exp=0", rd_req_rdy); end
      drain(16, 32'h100, e);
      total++; if (e != 0) begin bad++; $display("FAIL credit_drain got=%0d_errors exp=0", e); end
      rd_req_vld = 1'b1;
      rd_req_pd  = {4'hF, 32'h5000, 32'h0};
      #1;
      total++; if (rd_req_rdy !== 1'b1) begin bad++; $display("FAIL credit_rdy_reopen got=%b exp=1", rd_req_rdy); end
      tick();
      rd_req_vld = 1'b0;
      total++; if (arvalid !== 1'b1 || araddr !== 32'h5000) begin bad++; $display("FAIL credit_fifth_ar got=%b/%h exp=1/00005000", arvalid, araddr); end
      for (int b = 0; b < 4; b++) ret_burst(16, 16'h8000, 16'h0, 32'h200 + 32'(b * 16));
      total++; if (rready !== 1'b0) begin bad++; $display("FAIL credit_rready_full got=%b exp=0", rready); end
      drain(64, 32'h200, e);
      total++; if (e != 0) begin bad++; $display("FAIL credit_drain_all got=%0d_errors exp=0", e); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL credit_busy got=%b exp=0", busy); end
   endtask

   task automatic test_outst();
      int nacc = 0;
      int nar  = 0;
      arready    = 1'b1;
      dat_rdy    = 1'b1;
      rd_req_vld = 1'b1;
      rd_req_pd  = {4'h0, 32'h6000, 32'h0};
      for (int i = 0; i < 8; i++) begin
         if (arvalid) nar++;
         #1;
         if (rd_req_rdy) nacc++;
         tick();
      end
      total++; if (nacc != 4 || nar != 4) begin bad++; $display("FAIL outst_limit got=%0d/%0d exp=4/4", nacc, nar); end
      total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL outst_fifth_held got=%b exp=0", arvalid); end
      rvalid = 1'b1;
      rlast  = 1'b1;
      rdata  = {96'h0, 32'h300};
      #1;
      total++; if (rd_req_rdy !== 1'b1) begin bad++; $display("FAIL outst_rdy_on_rlast got=%b exp=1", rd_req_rdy); end
      tick();
      rvalid     = 1'b0;
      rlast      = 1'b0;
      rd_req_vld = 1'b0;
      total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL outst_fifth_issue got=%b exp=1", arvalid); end
      ret_burst(4, 16'h000F, 16'h0, 32'h301);
      tick(); tick();
      total++; if (busy !== 1'b0 || dat_vld !== 1'b0) begin bad++; $display("FAIL outst_idle got=%b/%b exp=0/0", busy, dat_vld); end
      dat_rdy = 1'b0;
   endtask

   task automatic test_hold();
      bit ok;
      int nb = 0;
      int e;
      arready = 1'b0;
      dat_rdy = 1'b0;
      send_cmd(4'd7, 32'h2000, 32'h100, ok);
      total++; if (!ok) begin bad++; $display("FAIL hold_accept got=timeout exp=accept"); end
      rd_req_vld = 1'b1;
      rd_req_pd  = {4'd2, 32'h3000, 32'h0};
      for (int i = 0; i < 5; i++) begin
         #1;
         if (arvalid !== 1'b1 || araddr !== 32'h2100 || arlen !== 8'd7 || rd_req_rdy !== 1'b0) nb++;
         tick();
      end
      total++; if (nb != 0) begin bad++; $display("FAIL hold_stable got=%0d_bad_cycles exp=0", nb); end
      arready = 1'b1;
      #1;
      total++; if (rd_req_rdy !== 1'b1) begin bad++; $display("FAIL hold_b2b_rdy got=%b exp=1", rd_req_rdy); end
      tick();
      rd_req_vld = 1'b0;
      total++; if (arvalid !== 1'b1 || araddr !== 32'h3000 || arlen !== 8'd2) begin bad++; $display("FAIL hold_b2b_ar got=%b/%h/%0d exp=1/00003000/2", arvalid, araddr, arlen); end
      tick();
      total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL hold_drop got=%b exp=0", arvalid); end
      ret_burst(8, 16'h0080, 16'h0, 32'h400);
      ret_burst(3, 16'h0004, 16'h0, 32'h408);
      drain(11, 32'h400, e);
      total++; if (e != 0 || err_rlast !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL hold_data got=%0d/%b/%b exp=0/0/0", e, err_rlast, busy); end
   endtask

   task automatic test_wrap();
      bit ok;
      int e;
      arready = 1'b1;
      send_cmd(4'd0, 32'hFFFF_FFF0, 32'h20, ok);
      total++; if (!ok || araddr !== 32'h0000_0010) begin bad++; $display("FAIL wrap_araddr got=%h exp=00000010", araddr); end
      tick();
      ret_burst(1, 16'h0001, 16'h0, 32'h500);
      drain(1, 32'h500, e);
      total++; if (e != 0 || busy !== 1'b0) begin bad++; $display("FAIL wrap_data got=%0d/%b exp=0/0", e, busy); end
   endtask

   task automatic test_errors();
      bit ok;
      int e;
      arready = 1'b1;
      dat_rdy = 1'b0;
      total++; if ({err_rresp, err_rlast} !== 2'b00) begin bad++; $display("FAIL err_initial got=%b exp=00", {err_rresp, err_rlast}); end
      send_cmd(4'd3, 32'h7000, 32'h0, ok);
      tick();
      ret_burst(4, 16'h0008, 16'h0002, 32'h600);
      drain(4, 32'h600, e);
      total++; if (!ok || e != 0) begin bad++; $display("FAIL err_rresp_data got=%0d_errors exp=0", e); end
      total++; if ({err_rresp, err_rlast} !== 2'b10) begin bad++; $display("FAIL err_rresp_flags got=%b exp=10", {err_rresp, err_rlast}); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      total++; if (err_rresp !== 1'b0) begin bad++; $display("FAIL err_rresp_clr got=%b exp=0", err_rresp); end
      send_cmd(4'd3, 32'h7100, 32'h0, ok);
      tick();
      ret_burst(4, 16'h000A, 16'h0, 32'h610);
      drain(4, 32'h610, e);
      total++; if (!ok || e != 0) begin bad++; $display("FAIL err_rlast_data got=%0d_errors exp=0", e); end
      total++; if ({err_rresp, err_rlast} !== 2'b01) begin bad++; $display("FAIL err_rlast_flags got=%b exp=01", {err_rresp, err_rlast}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_rlast_busy got=%b exp=0", busy); end
      send_cmd(4'd0, 32'h7200, 32'h0, ok);
      tick();
      rvalid  = 1'b1;
      rlast   = 1'b1;
      rresp   = 2'b10;
      rdata   = {96'h0, 32'h620};
      err_clr = 1'b1;
      tick();
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rresp   = 2'b00;
      err_clr = 1'b0;
      total++; if ({err_rresp, err_rlast} !== 2'b10) begin bad++; $display("FAIL err_set_wins got=%b exp=10", {err_rresp, err_rlast}); end
      drain(1, 32'h620, e);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      total++; if (!ok || e != 0 || {err_rresp, err_rlast} !== 2'b00) begin bad++; $display("FAIL err_final_clr got=%0d/%b exp=0/00", e, {err_rresp, err_rlast}); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_credit();
      test_outst();
      test_hold();
      test_wrap();
      test_errors();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
